// File: rtl/fft_pkg.sv
// Shared FFT types: complex sample payload and the frame controller state encoding.
package fft_pkg;

    `include "headers.svh"

    typedef enum logic [2:0] {
        CLEAR = 3'd0,
        LOAD  = 3'd1,
        FEED  = 3'd2,
        WAIT  = 3'd3,
        DRAIN = 3'd4
    } fft_ctrl_state_t;

endpackage

// File: rtl/fft_sample_buffer.sv
// N-entry sample register file: serial write port, paired read of entries k and k+N/2.
module fft_sample_buffer
    import fft_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [$clog2(N)-1:0]   wr_addr,
    input  complex_product_t       wr_data,
    input  logic [$clog2(N)-2:0]   rd_k,
    output complex_product_t       rd_data_0_c,
    output complex_product_t       rd_data_1_c
);

    complex_product_t [N-1:0] mem_q;
    complex_product_t [N-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // N is a power of two, so k+N/2 is k with the top address bit set.
    assign rd_data_0_c = mem_q[{1'b0, rd_k}];
    assign rd_data_1_c = mem_q[{1'b1, rd_k}];

endmodule

// File: rtl/headers.svh
// Complex sample type shared by the FFT and its frame controller.
localparam int unsigned CPLX_W = 16;

typedef struct packed {
    logic signed [CPLX_W-1:0] r;
    logic signed [CPLX_W-1:0] i;
} complex_product_t;

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for fft_8_rad2: buffer N samples, feed split-half pairs, capture and serialise.
// Optional WAIT watchdog enabled by defining FFT_CTRL_TIMEOUT_EN.
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned N       = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  complex_product_t         in_data,
    output logic                     fft_enable,
    output logic                     fft_clear,
    output complex_product_t         fft_data_0,
    output complex_product_t         fft_data_1,
    input  complex_product_t [N-1:0] fft_out,
    input  logic                     fft_out_valid,
    output logic                     out_valid,
    input  logic                     out_ready,
    output complex_product_t         out_data,
    output logic [$clog2(N)-1:0]     out_index,
    output logic                     out_last,
    output logic [15:0]              frames_done,
    output logic                     err_timeout
);

    localparam int unsigned AW   = $clog2(N);
    localparam int unsigned KW   = AW - 1;
    localparam int unsigned HALF = N / 2;

    if (N < 4 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("fft_frame_ctrl: N must be a power of two >= 4");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("fft_frame_ctrl: TIMEOUT must be at least 1");
    end

    fft_ctrl_state_t          state_q, state_d;
    logic [AW-1:0]            wr_idx_q, wr_idx_d;
    logic [KW-1:0]            k_q, k_d;
    logic [AW-1:0]            rd_idx_q, rd_idx_d;
    complex_product_t [N-1:0] obuf_q, obuf_d;
    logic [15:0]              frames_done_q, frames_done_d;

    logic                     in_ready_q, in_ready_d;
    logic                     fft_enable_q, fft_enable_d;
    logic                     fft_clear_q, fft_clear_d;
    complex_product_t         fft_data_0_q, fft_data_0_d;
    complex_product_t         fft_data_1_q, fft_data_1_d;
    logic                     out_valid_q, out_valid_d;
    complex_product_t         out_data_q, out_data_d;
    logic [AW-1:0]            out_index_q, out_index_d;
    logic                     out_last_q, out_last_d;

    logic                     ibuf_wr_en;
    complex_product_t         ibuf_rd_0, ibuf_rd_1;

`ifdef FFT_CTRL_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          err_q, err_d;
`endif

    fft_sample_buffer #(.N(N)) u_ibuf (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (ibuf_wr_en),
        .wr_addr     (wr_idx_q),
        .wr_data     (in_data),
        .rd_k        (k_d),
        .rd_data_0_c (ibuf_rd_0),
        .rd_data_1_c (ibuf_rd_1)
    );

    // Next-state, counters and buffer control.
    always_comb begin
        state_d       = state_q;
        wr_idx_d      = wr_idx_q;
        k_d           = k_q;
        rd_idx_d      = rd_idx_q;
        obuf_d        = obuf_q;
        frames_done_d = frames_done_q;
        ibuf_wr_en    = 1'b0;
`ifdef FFT_CTRL_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        err_d         = err_q;
`endif
        unique case (state_q)
            CLEAR: begin
                state_d  = LOAD;
                wr_idx_d = '0;
                k_d      = '0;
                rd_idx_d = '0;
            end
            LOAD: begin
                if (in_valid && in_ready_q) begin
                    ibuf_wr_en = 1'b1;
                    wr_idx_d   = wr_idx_q + AW'(1);
                    if (wr_idx_q == AW'(N - 1)) begin
                        state_d = FEED;
                        k_d     = '0;
                    end
                end
            end
            FEED: begin
                k_d = k_q + KW'(1);
                if (k_q == KW'(HALF - 1)) begin
                    state_d = WAIT;
`ifdef FFT_CTRL_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end
            end
            WAIT: begin
                // A result arriving on the timeout cycle still wins.
                if (fft_out_valid) begin
                    obuf_d   = fft_out;
                    rd_idx_d = '0;
                    state_d  = DRAIN;
                end
`ifdef FFT_CTRL_TIMEOUT_EN
                else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = CLEAR;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
`endif
            end
            DRAIN: begin
                if (out_valid_q && out_ready) begin
                    rd_idx_d = rd_idx_q + AW'(1);
                    if (rd_idx_q == AW'(N - 1)) begin
                        frames_done_d = frames_done_q + 16'd1;
                        state_d       = CLEAR;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Outputs are decoded from next state so they register in step with state_q.
    always_comb begin
        in_ready_d   = (state_d == LOAD);
        fft_clear_d  = (state_d == CLEAR);
        fft_enable_d = (state_d == FEED) || (state_d == WAIT);
        fft_data_0_d = '0;
        fft_data_1_d = '0;
        out_valid_d  = 1'b0;
        out_data_d   = '0;
        out_index_d  = '0;
        out_last_d   = 1'b0;
        if (state_d == FEED) begin
            fft_data_0_d = ibuf_rd_0;
            fft_data_1_d = ibuf_rd_1;
        end
        if (state_d == DRAIN) begin
            out_valid_d = 1'b1;
            out_data_d  = obuf_d[rd_idx_d];
            out_index_d = rd_idx_d;
            out_last_d  = (rd_idx_d == AW'(N - 1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= CLEAR;
            wr_idx_q      <= '0;
            k_q           <= '0;
            rd_idx_q      <= '0;
            obuf_q        <= '0;
            frames_done_q <= '0;
            in_ready_q    <= 1'b0;
            fft_enable_q  <= 1'b0;
            fft_clear_q   <= 1'b1;
            fft_data_0_q  <= '0;
            fft_data_1_q  <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_index_q   <= '0;
            out_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_idx_q      <= wr_idx_d;
            k_q           <= k_d;
            rd_idx_q      <= rd_idx_d;
            obuf_q        <= obuf_d;
            frames_done_q <= frames_done_d;
            in_ready_q    <= in_ready_d;
            fft_enable_q  <= fft_enable_d;
            fft_clear_q   <= fft_clear_d;
            fft_data_0_q  <= fft_data_0_d;
            fft_data_1_q  <= fft_data_1_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_index_q   <= out_index_d;
            out_last_q    <= out_last_d;
        end
    end

`ifdef FFT_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign in_ready    = in_ready_q;
    assign fft_enable  = fft_enable_q;
    assign fft_clear   = fft_clear_q;
    assign fft_data_0  = fft_data_0_q;
    assign fft_data_1  = fft_data_1_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_index   = out_index_q;
    assign out_last    = out_last_q;
    assign frames_done = frames_done_q;

endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer in front of `fft_8_rad2`. It accepts a serial stream of complex samples with a valid/ready handshake and buffers one N-point frame. It then drives the FFT's two-sample input port in split-half pair order and captures the parallel `fft_out` vector when `out_valid` rises. Finally it re-serialises the result onto a valid/ready output stream and clears the FFT before the next frame.

## Interface
- `N`, 8: FFT points; power of two, ≥4.
- `TIMEOUT`, 64: maximum WAIT cycles before the frame is abandoned (used only with `FFT_CTRL_TIMEOUT_EN`).
- `clk` in 1: single clock, all logic on posedge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `in_valid` in 1, `in_ready` out 1, `in_data` in `complex_product_t`: sample input stream.
- `fft_enable` out 1: to FFT `enable`.
- `fft_clear` out 1: to FFT `reset` (active-high).
- `fft_data_0`, `fft_data_1` out `complex_product_t`: to FFT inputs.
- `fft_out` in `complex_product_t [N-1:0]`: FFT result vector.
- `fft_out_valid` in 1: from FFT `out_valid`.
- `out_valid` out 1, `out_ready` in 1, `out_data` out `complex_product_t`: result stream.
- `out_index` out `$clog2(N)`: bin number of `out_data`.
- `out_last` out 1: high with bin N-1.
- `frames_done` out 16: completed-frame counter; wraps at 0xFFFF→0.
- `err_timeout` out 1: sticky timeout flag.

## Operation
- FSM states: CLEAR, LOAD, FEED, WAIT, DRAIN. Reset state is CLEAR.
- CLEAR (1 cycle): `fft_clear`=1, `fft_enable`=0. Next state is LOAD.
- LOAD: `in_ready`=1. Each `in_valid&&in_ready` writes `ibuf[wr_idx]` and increments `wr_idx`. After the write with `wr_idx`==N-1, go to FEED. Gaps in `in_valid` are legal and stall the count.
- FEED (exactly N/2 consecutive cycles, k=0..N/2-1): `fft_enable`=1, `fft_data_0`=`ibuf[k]`, `fft_data_1`=`ibuf[k+N/2]`. Go to WAIT after k=N/2-1.
- WAIT: `fft_enable`=1, `fft_data_0`/`fft_data_1`=0.
  - On `fft_out_valid`=1: capture `fft_out[0..N-1]` into `obuf` and go to DRAIN.
  - `fft_out_valid` outside WAIT is ignored.
- DRAIN: `fft_enable`=0, `out_valid`=1, `out_data`=`obuf[rd_idx]`, `out_index`=`rd_idx`, `out_last`=(`rd_idx`==N-1).
  - `rd_idx` advances only on `out_valid&&out_ready`.
  - `out_data` is held stable while stalled.
  - On the last transfer: `frames_done`++ and go to CLEAR.
- `in_ready`=0 in every state except LOAD. There is no overlap: the next frame is accepted only after CLEAR.
- Simultaneous events:
  - The last `in_data` accept and the LOAD→FEED transition happen on the same edge.
  - If a timeout and `fft_out_valid` occur in the same cycle, `fft_out_valid` wins and no error is flagged.
- Reset mid-operation (any state): the frame is discarded. All outputs take their reset values and `ibuf`/`obuf` contents become don't-care.
- Data is passed unmodified. There is no arithmetic on samples, and widths equal `complex_product_t` throughout.

## Timing
- Reset values:
  - `fft_clear`=1, because the state is CLEAR.
  - `in_ready`=0, `fft_enable`=0, `fft_data_*`=0.
  - `out_valid`=0, `out_data`=0, `out_index`=0, `out_last`=0.
  - `frames_done`=0, `err_timeout`=0.
- After `reset` deasserts: the first posedge moves CLEAR→LOAD, so `in_ready`=1 from that cycle onward.
- All outputs are decoded from registered state or counters; there is no combinational path from input to output.
- Cycle count per frame, excluding stalls: 1 (CLEAR) + N (LOAD) + N/2 (FEED) + L_fft (WAIT) + N (DRAIN).
- `fft_out` is sampled on the posedge at which `fft_out_valid`=1. The first `out_valid` appears the cycle after that posedge.

## Configuration
- `FFT_CTRL_TIMEOUT_EN` defined:
  - A WAIT cycle counter runs and resets on entry to WAIT.
  - When it reaches TIMEOUT without `fft_out_valid`: set `err_timeout`=1 (sticky until `reset`), drop the frame, and go to CLEAR. `frames_done` is not incremented.
- `FFT_CTRL_TIMEOUT_EN` undefined: WAIT persists indefinitely, and `err_timeout` is tied to 0.

## Structure
- Shared package `fft_pkg`: `fft_ctrl_state_t` enum (CLEAR, LOAD, FEED, WAIT, DRAIN). `complex_product_t` remains in `headers.svh`.
- Sub-module `fft_sample_buffer`: N-entry register file with one serial write port and one dual-address read port (`k`, `k+N/2`). It is instantiated for `ibuf`; `obuf` is a plain parallel-load register array.

## Test plan
- Ramp frame 0..7 (real), `out_ready`=1 → FEED pairs (0,4),(1,5),(2,6),(3,7) on 4 consecutive cycles; `out_data` equals `fft_out` at `fft_out_valid`, indices 0..7, `out_last` only at 7; `frames_done`=1.
- DC frame of all `r`=1, `i`=0 → bin 0 `r`=8, bins 1..7 = 0; `in_valid` toggling every other cycle → LOAD takes 15 cycles and FEED is still 4 back-to-back cycles.
- `out_ready` low for 5 cycles at `rd_idx`=3 → `out_data`/`out_index` held at bin 3 with no loss or duplicate, and `in_ready`=0 throughout.
- Stub FFT that never asserts `fft_out_valid`, TIMEOUT=64, macro on → `err_timeout`=1 exactly 64 cycles into WAIT, one CLEAR cycle follows, `frames_done` unchanged, next frame processes normally.
- `reset` asserted during FEED k=2 → all outputs take their reset values immediately; after release a new ramp frame produces correct output.
- 3 back-to-back frames → each is separated by exactly one `fft_clear` cycle; `frames_done`=3.
